// File: rtl/fastmont_pkg.sv
// ---------------------------------------------------------------------------
// fastmont_pkg
// Shared constants and types for the Montgomery datapath blocks.
//   FM_N        : operand width of the wide arithmetic (adder result is FM_N+1)
//   FM_ADD_LAT  : default latency of the shared mpadder4 adder/subtractor
//   state_t     : sequencer states used by mod_addsub_ctrl
// ---------------------------------------------------------------------------
package fastmont_pkg;

    localparam int FM_N       = 1027;
    localparam int FM_ADD_LAT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2
    } state_t;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// mod_addsub_ctrl
// Computes (a + b) mod m or (a - b) mod m by running the external mpadder4
// over one or two passes. The first pass forms a+b or a-b; the second pass
// (always for add, only on borrow for sub) applies the modulus correction.
//
// Ports
//   clk, resetn          : rising-edge clock, synchronous active-low reset
//   start, subtract      : request strobe (IDLE only) and operation select
//   in_a, in_b, in_m     : operands, captured on the accepting edge
//   busy                 : high whenever the sequencer is not IDLE
//   done                 : one-cycle pulse on the edge that writes result
//   result               : reduced result, held until the next completion
//   adder_a/b, adder_sub : registered operands and mode driven to the adder
//   adder_result         : N+1 bit adder output, bit N = carry / borrow
// ---------------------------------------------------------------------------
module mod_addsub_ctrl
    import fastmont_pkg::*;
#(
    parameter int N       = FM_N,
    parameter int ADD_LAT = FM_ADD_LAT
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         subtract,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [N-1:0] adder_a,
    output logic [N-1:0] adder_b,
    output logic         adder_sub,
    input  logic [N:0]   adder_result
);

    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    generate
        if (ADD_LAT < 1) begin : g_bad_lat
            $error("mod_addsub_ctrl: ADD_LAT must be at least 1");
        end
    endgenerate

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          last;

    // Captured request context; a and b go straight into adder_a/adder_b.
    logic          sub_q;
    logic [N-1:0]  m_q;
    logic [N:0]    s_q;      // first-pass sum (add only), bit N is the carry

    logic          accept;
    logic          p1_fire;
    logic          p2_fire;
    logic          borrow;
    logic          sub_direct;
    logic          fin;
    logic [N-1:0]  res_nxt;

    // The adder is only trusted on the last counted edge of each pass.
    assign last = (cnt == CW'(ADD_LAT - 1));

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_PASS1;
            // A subtract without borrow is already in range: finish in PASS1.
            ST_PASS1: if (last)  state_nxt = (sub_q && !adder_result[N]) ? ST_IDLE : ST_PASS2;
            ST_PASS2: if (last)  state_nxt = ST_IDLE;
            default:             state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        accept     = (state == ST_IDLE) && start;
        p1_fire    = (state == ST_PASS1) && last;
        p2_fire    = (state == ST_PASS2) && last;
        borrow     = adder_result[N];
        sub_direct = p1_fire && sub_q && !borrow;
        fin        = sub_direct || p2_fire;
        busy       = (state != ST_IDLE);

        // Default: low bits of the current adder output (sub direct, sub
        // corrected, or add where S >= m / S overflowed). Add keeps S only
        // when S had no carry and S - m borrowed.
        res_nxt = adder_result[N-1:0];
        if (p2_fire && !sub_q && !s_q[N] && borrow)
            res_nxt = s_q[N-1:0];
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (!resetn) begin
            done      <= 1'b0;
            result    <= '0;
            adder_a   <= '0;
            adder_b   <= '0;
            adder_sub <= 1'b0;
            sub_q     <= 1'b0;
            m_q       <= '0;
            s_q       <= '0;
            cnt       <= '0;
        end else begin
            done <= fin;

            if (fin)
                result <= res_nxt;

            if (accept) begin
                adder_a   <= in_a;
                adder_b   <= in_b;
                adder_sub <= subtract;
                sub_q     <= subtract;
                m_q       <= in_m;
                cnt       <= '0;
            end else if (state != ST_IDLE) begin
                cnt <= last ? '0 : cnt + CW'(1);
            end

            // Set up the correction pass: add subtracts m, sub adds m back.
            if (p1_fire && !sub_direct) begin
                adder_a   <= adder_result[N-1:0];
                adder_b   <= m_q;
                adder_sub <= ~sub_q;
            end

            if (p1_fire && !sub_q)
                s_q <= adder_result;
        end
    end

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mod_addsub_ctrl
// Two instances of the sequencer (ADD_LAT=1 and ADD_LAT=3), each paired with
// a behavioural mpadder4 whose output is valid exactly ADD_LAT cycles after
// its operands change (stale beforehand). A vector table is replayed on both,
// followed by back-to-back, busy-start, and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_mod_addsub_ctrl;
    import fastmont_pkg::*;

    localparam int N = FM_N;

    typedef struct {
        logic         sub;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] m;
        logic [N-1:0] exp;
        int           passes;
        bit           chk;
        string        nm;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic         subtract;
    logic [N-1:0] in_a, in_b, in_m;
    logic         start1, start3;

    logic         busy1, done1, asub1;
    logic [N-1:0] result1, aa1, ab1;
    logic [N:0]   ar1, sum1;

    logic         busy3, done3, asub3;
    logic [N-1:0] result3, aa3, ab3;
    logic [N:0]   ar3, sum3, p3_0, p3_1;

    mod_addsub_ctrl #(.N(N), .ADD_LAT(1)) u_lat1 (
        .clk(clk), .resetn(resetn), .start(start1), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .busy(busy1), .done(done1), .result(result1),
        .adder_a(aa1), .adder_b(ab1), .adder_sub(asub1), .adder_result(ar1)
    );

    mod_addsub_ctrl #(.N(N), .ADD_LAT(3)) u_lat3 (
        .clk(clk), .resetn(resetn), .start(start3), .subtract(subtract),
        .in_a(in_a), .in_b(in_b), .in_m(in_m),
        .busy(busy3), .done(done3), .result(result3),
        .adder_a(aa3), .adder_b(ab3), .adder_sub(asub3), .adder_result(ar3)
    );

    // Adder models: combinational for latency 1, two extra stages for 3.
    always_comb sum1 = asub1 ? ({1'b0, aa1} - {1'b0, ab1}) : ({1'b0, aa1} + {1'b0, ab1});
    assign ar1 = sum1;

    always_comb sum3 = asub3 ? ({1'b0, aa3} - {1'b0, ab3}) : ({1'b0, aa3} + {1'b0, ab3});
    always_ff @(posedge clk) begin
        p3_0 <= sum3;
        p3_1 <= p3_0;
    end
    assign ar3 = p3_1;

    int npass = 0;
    int ntot  = 0;

    function automatic logic get_busy(input int s);
        return (s == 0) ? busy1 : busy3;
    endfunction
    function automatic logic get_done(input int s);
        return (s == 0) ? done1 : done3;
    endfunction
    function automatic logic [N-1:0] get_result(input int s);
        return (s == 0) ? result1 : result3;
    endfunction
    function automatic logic [N-1:0] get_aa(input int s);
        return (s == 0) ? aa1 : aa3;
    endfunction
    function automatic logic [N-1:0] get_ab(input int s);
        return (s == 0) ? ab1 : ab3;
    endfunction
    function automatic logic get_asub(input int s);
        return (s == 0) ? asub1 : asub3;
    endfunction

    function automatic vec_t mk(input logic sb, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [N-1:0] m, input logic [N-1:0] e,
                                input int p, input bit c, input string nm);
        vec_t v;
        v.sub = sb; v.a = a; v.b = b; v.m = m; v.exp = e;
        v.passes = p; v.chk = c; v.nm = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h (low 64 bits)", nm, act[63:0], exp[63:0]);
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Present a request at a negedge; returns just after the accepting edge.
    task automatic issue(input int s, input logic sb, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic [N-1:0] m, input string nm);
        subtract = sb; in_a = a; in_b = b; in_m = m;
        if (s == 0) start1 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
        check_i({nm, " busy after accept"}, int'(get_busy(s)), 1);
    endtask

    // Counts edges after the accepting edge until done; bounded.
    task automatic wait_done(input int s, input int lat, input bit chk,
                             input logic [N-1:0] exp, input string nm);
        int k = 0;
        while (!get_done(s) && k < 40) begin
            @(negedge clk);
            start1 = 1'b0; start3 = 1'b0;
            k++;
        end
        check_i({nm, " latency"}, k, lat);
        if (chk) check({nm, " result"}, get_result(s), exp);
    endtask

    task automatic end_pulse(input int s, input string nm);
        @(negedge clk);
        check_i({nm, " done one cycle"}, int'(get_done(s)), 0);
        check_i({nm, " idle after done"}, int'(get_busy(s)), 0);
    endtask

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] mbig;
        int           lat;
        bit           seen;

        mbig = '1;
        resetn = 1'b0; start1 = 1'b0; start3 = 1'b0; subtract = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;
        repeat (3) @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            check_i("reset busy", int'(get_busy(s)), 0);
            check_i("reset done", int'(get_done(s)), 0);
            check("reset result", get_result(s), '0);
            check("reset adder_a", get_aa(s), '0);
            check("reset adder_b", get_ab(s), '0);
            check_i("reset adder_sub", int'(get_asub(s)), 0);
        end
        resetn = 1'b1;
        @(negedge clk);

        vecs[0]  = mk(1'b0, 'h5, 'h7, 'hB, 'h1, 2, 1'b1, "add 5+7");
        vecs[1]  = mk(1'b0, 'h3, 'h4, 'hB, 'h7, 2, 1'b1, "add 3+4");
        vecs[2]  = mk(1'b1, 'h7, 'h3, 'hB, 'h4, 1, 1'b1, "sub 7-3");
        vecs[3]  = mk(1'b1, 'h3, 'h7, 'hB, 'h7, 2, 1'b1, "sub 3-7");
        vecs[4]  = mk(1'b0, mbig - 1, mbig - 1, mbig, mbig - 2, 2, 1'b1, "add carry");
        vecs[5]  = mk(1'b1, '0, mbig - 1, mbig, 'h1, 2, 1'b1, "sub 0-(m-1)");
        vecs[6]  = mk(1'b0, 'h0, 'h0, 'hB, 'h0, 2, 1'b1, "add 0+0");
        vecs[7]  = mk(1'b0, 'hA, 'h0, 'hB, 'hA, 2, 1'b1, "add (m-1)+0");
        vecs[8]  = mk(1'b0, 'h5, 'h6, 'hB, 'h0, 2, 1'b1, "add sum=m");
        vecs[9]  = mk(1'b1, 'h5, 'h5, 'hB, 'h0, 1, 1'b1, "sub 5-5");
        vecs[10] = mk(1'b0, 'h5, 'h7, 'h0, 'h0, 2, 1'b0, "add m=0");

        for (int s = 0; s < 2; s++) begin
            lat = (s == 0) ? 1 : 3;

            foreach (vecs[i]) begin
                issue(s, vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].nm);
                wait_done(s, vecs[i].passes * lat, vecs[i].chk, vecs[i].exp, vecs[i].nm);
                end_pulse(s, vecs[i].nm);
            end

            // Back-to-back: second request raised in the done cycle.
            issue(s, 1'b0, 'h5, 'h7, 'hB, "b2b first");
            wait_done(s, 2 * lat, 1'b1, 'h1, "b2b first");
            issue(s, 1'b1, 'h3, 'h7, 'hB, "b2b second");
            check("b2b result held", get_result(s), 'h1);
            wait_done(s, 2 * lat, 1'b1, 'h7, "b2b second");
            end_pulse(s, "b2b second");

            // start while busy with different operands must be ignored.
            issue(s, 1'b1, 'h3, 'h7, 'hB, "busy start");
            subtract = 1'b0; in_a = 'h1; in_b = 'h1; in_m = 'h3;
            if (s == 0) start1 = 1'b1; else start3 = 1'b1;
            wait_done(s, 2 * lat, 1'b1, 'h7, "busy start");
            end_pulse(s, "busy start");

            // Reset while in PASS2 aborts without a done pulse.
            issue(s, 1'b0, 'h5, 'h7, 'hB, "abort");
            repeat (lat) @(negedge clk);
            resetn = 1'b0;
            @(negedge clk);
            check_i("abort busy", int'(get_busy(s)), 0);
            check_i("abort done", int'(get_done(s)), 0);
            check("abort result", get_result(s), '0);
            resetn = 1'b1;
            seen = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (get_done(s)) seen = 1'b1;
            end
            check_i("abort no done", int'(seen), 0);

            issue(s, 1'b0, 'h3, 'h4, 'hB, "after abort");
            wait_done(s, 2 * lat, 1'b1, 'h7, "after abort");
            end_pulse(s, "after abort");
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/mod_addsub_ctrl.md
# mod_addsub_ctrl

Sequencer that computes modular addition or subtraction, (a ± b) mod m, on 1027-bit operands by driving the shared `mpadder4` adder/subtractor over one or two passes. It sits between the Montgomery top-level control and the adder instance. It owns the adder operand and mode inputs while busy, and returns a reduced 1027-bit result with a start/done handshake.

## Interface
- `N`, 1027: operand width; adder result width is N+1.
- `ADD_LAT`, 1: cycles from an adder operand change to a valid `adder_result`; must be ≥ 1.
- `clk` in 1: rising-edge clock.
- `resetn` in 1: synchronous, active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `subtract` in 1: 0 computes (a+b) mod m; 1 computes (a−b) mod m.
- `in_a`, `in_b`, `in_m` in N: operands; latched on the accepted start edge.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse when `result` is updated.
- `result` out N: reduced result; holds until the next completion.
- `adder_a`, `adder_b` out N: registered adder operands.
- `adder_sub` out 1: registered adder mode.
- `adder_result` in N+1: adder output, {1'b0,x} ± {1'b0,y} mod 2^(N+1); bit N is carry (add) or borrow (sub).

## Operation
- **Reset values.** `busy`, `done`, `adder_sub` = 0; `result`, `adder_a`, `adder_b` = 0; state IDLE, wait counter 0.
- **States.**
  - IDLE → PASS1 on `start`.
  - PASS1 → PASS2 or IDLE.
  - PASS2 → IDLE.
- **Wait counter.** Each PASS state waits ADD_LAT cycles, then samples `adder_result` on the final edge.
- **Accepting a request.** On the accepting edge, latch `in_a`, `in_b`, `in_m`, `subtract`, and load `adder_a`=a, `adder_b`=b, `adder_sub`=subtract.
- **Add, PASS1.**
  - Sample S = a+b; store S.
  - Load `adder_a`=S[N−1:0], `adder_b`=m, `adder_sub`=1.
  - Go to PASS2.
- **Add, PASS2.**
  - Sample D = S[N−1:0] − m.
  - `result` = (S[N] | ~D[N]) ? D[N−1:0] : S[N−1:0].
- **Sub, PASS1.** Sample D = a−b.
  - If D[N]=0: `result` = D[N−1:0]; go to IDLE. No second pass.
  - Else: load `adder_a`=D[N−1:0], `adder_b`=m, `adder_sub`=0; go to PASS2.
- **Sub, PASS2.** `result` = `adder_result`[N−1:0] (low N bits of D+m).
- **Completion.** On the edge that writes `result`: `done` ← 1 and state ← IDLE. `done` clears on the next edge.
- **Operand requirements.** In-range operands (a, b < m) give exact results. Out-of-range operands, or m=0, give an unspecified `result`, but the block must finish with normal latency and never hang.
- **Adder operands after completion.** `adder_a`, `adder_b`, `adder_sub` hold their last values in IDLE.

## Timing
- Accepting edge is T0.
- Add: `done` high in the cycle after edge T0+2·ADD_LAT.
- Sub without correction: `done` high after edge T0+ADD_LAT.
- Sub with correction: `done` high after edge T0+2·ADD_LAT.
- `start` while busy is ignored and has no effect on latched operands.
- `start` in the cycle `done` is high is accepted (state is IDLE), so requests can run back-to-back.
- `resetn`=0 mid-operation aborts on the next edge: all outputs take reset values and no `done` is issued for the aborted request.
- `result` changes only on completion edges and on reset.

## Structure
- Shared package `fastmont_pkg` holds N=1027, the state encodings (IDLE, PASS1, PASS2), and the default ADD_LAT.
- No sub-modules. The adder is external; the integration top connects `mpadder4` to the `adder_*` ports.
- The bench wraps the block plus one `mpadder4` instance and drives `resetn`, `start`, `subtract`, `in_a`, `in_b`, `in_m`. `mpadder4` exposes no mode port for `adder_sub`; the bench drives the adder mode from `adder_sub` as specified here.

## Test plan
All values hex, ADD_LAT=1 unless stated.
- Add 5+7, m=B → `result`=1, `done` after 2 edges. Add 3+4, m=B → 7 (no reduction, same latency).
- Sub 7−3, m=B → 4, `done` after 1 edge. Sub 3−7, m=B → 7, `done` after 2 edges.
- Add with m=2^1027−1, a=b=m−1 (S[N]=1 path) → `result`=2^1027−3. Sub with a=0, b=m−1 → 1.
- Back-to-back: second `start` in the `done` cycle → both results correct, no idle gap. A `start` pulse while busy with different operands → ignored; first result unchanged.
- Reset asserted in PASS2 → next cycle `busy`=0, `done`=0, `result`=0, no `done` pulse afterwards. A new request then completes normally.
- ADD_LAT=3 rerun of all of the above → latencies 6 (add) and 3 or 6 (sub); `adder_result` sampled only on the final counted edge.
